i2c_dyn_seq: RTL and testbench

//  Parametrised dynamic-mode sequencer for the I2C master. Parses command words at the TX FIFO head
//  and counts received bytes, then drives set/clear pulses into the control register (MSMS, RSTA, TXAK, TX).

---
 rtl/i2c_dyn_pkg.sv | 27 ++
 rtl/i2c_dyn_seq_start_det.sv | 29 ++
 rtl/i2c_dyn_seq.sv | 166 ++++++++++++++++
 tb/tb_i2c_dyn_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_dyn_pkg.sv
// Shared types and constants for the I2C dynamic-mode sequencer.
// Flag positions are counted down from the top bit of the TX word.
package i2c_dyn_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_RCNT,
    S_READ,
    S_WRITE
  } state_t;

  localparam int STOP_BIT  = 1;
  localparam int START_BIT = 2;

  localparam int P_MSMS_SET = 0;
  localparam int P_MSMS_CLR = 1;
  localparam int P_RSTA_SET = 2;
  localparam int P_TXAK_SET = 3;
  localparam int P_TXAK_CLR = 4;
  localparam int P_TX_SET   = 5;
  localparam int P_TX_CLR   = 6;
  localparam int P_ABORT    = 7;
  localparam int P_ERR      = 8;
  localparam int NPULSE     = 9;

endpackage

// File: rtl/i2c_dyn_seq_start_det.sv
// Start-word detector: flags the first cycle a start word
// is visible at the FIFO head or pushed into an empty FIFO.
module i2c_dyn_seq_start_det (
  input  logic clk,
  input  logic rstn,
  input  logic empty,
  input  logic wr,
  input  logic head_start,
  input  logic push_start,
  output logic start_set
);

  logic start;
  logic start_hold;

  assign start = (!empty && head_start) ||
                 (empty && wr && push_start);

  assign start_set = start && !start_hold;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_hold <= 1'b0;
    end else begin
      start_hold <= start;
    end
  end

endmodule

// File: rtl/i2c_dyn_seq.sv
// Dynamic-mode sequencer: parses TX command words and RX byte
// counts into registered set/clear pulses for the I2C control register.
module i2c_dyn_seq
  import i2c_dyn_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int ZERO_CNT_MODE = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cr_en,
  input  logic             cr_msms,
  input  logic             arb_lost,
  input  logic             tx_fifo_empty,
  input  logic             tx_fifo_rd,
  input  logic [CNT_W+1:0] tx_fifo_dout,
  input  logic             tx_fifo_wr,
  input  logic [CNT_W+1:0] tx_fifo_din,
  input  logic             rx_fifo_wr,
  output logic             dyna_msms_set,
  output logic             dyna_msms_clr,
  output logic             dyna_rsta_set,
  output logic             dyna_txak_set,
  output logic             dyna_txak_clr,
  output logic             dyna_tx_set,
  output logic             dyna_tx_clr,
  output logic             dyna_abort,
  output logic             dyna_err,
  output logic             seq_busy,
  output logic [CNT_W-1:0] rd_remaining
);

  localparam int DW   = CNT_W + 2;
  localparam int RC_W = CNT_W + 1;

  state_t            state, state_n;
  logic [RC_W-1:0]   rcnt, rcnt_n;
  logic              stp, stp_n;
  logic [NPULSE-1:0] pulse_q, pulse_n;
  logic              start_set;
  logic              abort;
  logic [CNT_W-1:0]  cnt;
  logic [DW-2:0]     din_unused;

  assign din_unused = {tx_fifo_din[DW-1],
                       tx_fifo_din[DW-3:0]};

  i2c_dyn_seq_start_det u_start_det (
    .clk        (clk),
    .rstn       (rstn),
    .empty      (tx_fifo_empty),
    .wr         (tx_fifo_wr),
    .head_start (tx_fifo_dout[DW-START_BIT]),
    .push_start (tx_fifo_din[DW-START_BIT]),
    .start_set  (start_set)
  );

  assign cnt   = tx_fifo_dout[CNT_W-1:0];
  assign abort = arb_lost ||
                 (!cr_en && state != S_IDLE);

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    stp_n   = stp;
    pulse_n = '0;
    if (abort) begin
      pulse_n[P_ABORT] = 1'b1;
      state_n          = S_IDLE;
      rcnt_n           = '0;
    end else if (start_set && cr_en) begin
      if (!cr_msms) begin
        pulse_n[P_MSMS_SET] = 1'b1;
      end else begin
        pulse_n[P_RSTA_SET] = 1'b1;
      end
      pulse_n[P_TXAK_CLR] = 1'b1;
      state_n             = S_ADDR;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (tx_fifo_rd) begin
            if (tx_fifo_dout[0]) begin
              pulse_n[P_TX_CLR] = 1'b1;
              state_n           = S_RCNT;
            end else begin
              pulse_n[P_TX_SET] = 1'b1;
              state_n           = S_WRITE;
            end
          end
        end
        S_RCNT: begin
          if (tx_fifo_rd) begin
            stp_n = tx_fifo_dout[DW-STOP_BIT];
            if (cnt == '0) begin
              if (ZERO_CNT_MODE == 0) begin
                pulse_n[P_ERR]   = 1'b1;
                pulse_n[P_ABORT] = 1'b1;
                rcnt_n           = '0;
                state_n          = S_IDLE;
              end else begin
                rcnt_n  = {1'b1, {CNT_W{1'b0}}};
                state_n = S_READ;
              end
            end else begin
              if (cnt == CNT_W'(1)) begin
                pulse_n[P_TXAK_SET] = 1'b1;
              end
              rcnt_n  = {1'b0, cnt};
              state_n = S_READ;
            end
          end
        end
        S_READ: begin
          if (rx_fifo_wr && rcnt != '0) begin
            rcnt_n = rcnt - RC_W'(1);
            if (rcnt == RC_W'(2)) begin
              pulse_n[P_TXAK_SET] = 1'b1;
            end
            if (rcnt == RC_W'(1)) begin
              pulse_n[P_MSMS_CLR] = stp;
              state_n             = S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (tx_fifo_rd && tx_fifo_dout[DW-STOP_BIT]) begin
            pulse_n[P_MSMS_CLR] = 1'b1;
            pulse_n[P_TX_CLR]   = 1'b1;
            state_n             = S_IDLE;
          end
        end
        default: begin
          state_n = state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      rcnt    <= '0;
      stp     <= 1'b0;
      pulse_q <= '0;
    end else begin
      state   <= state_n;
      rcnt    <= rcnt_n;
      stp     <= stp_n;
      pulse_q <= pulse_n;
    end
  end

  assign dyna_msms_set = pulse_q[P_MSMS_SET];
  assign dyna_msms_clr = pulse_q[P_MSMS_CLR];
  assign dyna_rsta_set = pulse_q[P_RSTA_SET];
  assign dyna_txak_set = pulse_q[P_TXAK_SET];
  assign dyna_txak_clr = pulse_q[P_TXAK_CLR];
  assign dyna_tx_set   = pulse_q[P_TX_SET];
  assign dyna_tx_clr   = pulse_q[P_TX_CLR];
  assign dyna_abort    = pulse_q[P_ABORT];
  assign dyna_err      = pulse_q[P_ERR];
  assign seq_busy      = (state != S_IDLE);
  assign rd_remaining  = rcnt[CNT_W-1:0];

endmodule

// File: tb/tb_i2c_dyn_seq.sv
// Directed bench for i2c_dyn_seq; instance u0 runs zero-count
// mode 0, u1 mode 1, both on the same stimulus.
module tb_i2c_dyn_seq;

  localparam int CW = 8;
  localparam int DW = CW + 2;

  localparam logic [8:0] MS  = 9'h001;
  localparam logic [8:0] MC  = 9'h002;
  localparam logic [8:0] RS  = 9'h004;
  localparam logic [8:0] KS  = 9'h008;
  localparam logic [8:0] KC  = 9'h010;
  localparam logic [8:0] TS  = 9'h020;
  localparam logic [8:0] TC  = 9'h040;
  localparam logic [8:0] AB  = 9'h080;
  localparam logic [8:0] ER  = 9'h100;
  localparam logic [8:0] NIL = 9'h000;

  logic clk = 1'b0;
  logic rstn, cr_en, cr_msms, arb_lost;
  logic empty, rd, wr, rxw;
  logic [DW-1:0] dout, din;

  logic [8:0] p0, p1;
  logic busy0, busy1;
  logic [CW-1:0] rem0, rem1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  i2c_dyn_seq #(.CNT_W(CW), .ZERO_CNT_MODE(0)) u0 (
    .clk(clk), .rstn(rstn), .cr_en(cr_en),
    .cr_msms(cr_msms), .arb_lost(arb_lost),
    .tx_fifo_empty(empty), .tx_fifo_rd(rd),
    .tx_fifo_dout(dout), .tx_fifo_wr(wr),
    .tx_fifo_din(din), .rx_fifo_wr(rxw),
    .dyna_msms_set(p0[0]), .dyna_msms_clr(p0[1]),
    .dyna_rsta_set(p0[2]), .dyna_txak_set(p0[3]),
    .dyna_txak_clr(p0[4]), .dyna_tx_set(p0[5]),
    .dyna_tx_clr(p0[6]), .dyna_abort(p0[7]),
    .dyna_err(p0[8]), .seq_busy(busy0),
    .rd_remaining(rem0)
  );

  i2c_dyn_seq #(.CNT_W(CW), .ZERO_CNT_MODE(1)) u1 (
    .clk(clk), .rstn(rstn), .cr_en(cr_en),
    .cr_msms(cr_msms), .arb_lost(arb_lost),
    .tx_fifo_empty(empty), .tx_fifo_rd(rd),
    .tx_fifo_dout(dout), .tx_fifo_wr(wr),
    .tx_fifo_din(din), .rx_fifo_wr(rxw),
    .dyna_msms_set(p1[0]), .dyna_msms_clr(p1[1]),
    .dyna_rsta_set(p1[2]), .dyna_txak_set(p1[3]),
    .dyna_txak_clr(p1[4]), .dyna_tx_set(p1[5]),
    .dyna_tx_clr(p1[6]), .dyna_abort(p1[7]),
    .dyna_err(p1[8]), .seq_busy(busy1),
    .rd_remaining(rem1)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  // one clock; strobes self-clear after the edge
  task automatic step();
    @(posedge clk);
    #1;
    rd       = 1'b0;
    wr       = 1'b0;
    rxw      = 1'b0;
    arb_lost = 1'b0;
  endtask

  task automatic head(input logic [DW-1:0] w,
                      input logic pop);
    empty = 1'b0;
    dout  = w;
    rd    = pop;
    step();
  endtask

  task automatic drain();
    empty = 1'b1;
    dout  = '0;
    step();
  endtask

  task automatic rx();
    rxw = 1'b1;
    step();
  endtask

  initial begin
    rstn = 1'b0; cr_en = 1'b1; cr_msms = 1'b0;
    arb_lost = 1'b0; empty = 1'b1; rd = 1'b0;
    wr = 1'b0; rxw = 1'b0; dout = '0; din = '0;
    step();
    check("rst_pulse", 32'(p0), 32'(NIL));
    check("rst_busy", 32'(busy0), 0);
    check("rst_rem", 32'(rem0), 0);
    rstn = 1'b1;
    step();

    // idle pop ignored
    head(10'h0A5, 1'b1);
    check("idle_pop", 32'(p0), 32'(NIL));
    drain();

    // 1: write with stop
    head(10'h1A0, 1'b0);
    check("w_start", 32'(p0), 32'(MS | KC));
    check("w_busy", 32'(busy0), 1);
    head(10'h1A0, 1'b1);
    check("w_addr", 32'(p0), 32'(TS));
    head(10'h011, 1'b1);
    check("w_data", 32'(p0), 32'(NIL));
    head(10'h222, 1'b1);
    check("w_stop", 32'(p0), 32'(MC | TC));
    drain();
    check("w_idle", 32'(busy0), 0);

    // 2: read 3 with stop
    head(10'h1A1, 1'b0);
    check("r3_start", 32'(p0), 32'(MS | KC));
    head(10'h1A1, 1'b1);
    check("r3_addr", 32'(p0), 32'(TC));
    head(10'h203, 1'b1);
    check("r3_load", 32'(p0), 32'(NIL));
    check("r3_rem3", 32'(rem0), 3);
    drain();
    rx();
    check("r3_rx1", 32'(p0), 32'(NIL));
    check("r3_rem2", 32'(rem0), 2);
    rx();
    check("r3_rx2", 32'(p0), 32'(KS));
    check("r3_rem1", 32'(rem0), 1);
    rx();
    check("r3_rx3", 32'(p0), 32'(MC));
    check("r3_rem0", 32'(rem0), 0);
    check("r3_idle", 32'(busy0), 0);
    rx();
    check("r3_rx_idle", 32'(p0), 32'(NIL));

    // 3: read 1 no stop, then repeated-start write
    head(10'h1A1, 1'b0);
    check("r1_start", 32'(p0), 32'(MS | KC));
    head(10'h1A1, 1'b1);
    check("r1_addr", 32'(p0), 32'(TC));
    head(10'h001, 1'b1);
    check("r1_load", 32'(p0), 32'(KS));
    check("r1_rem", 32'(rem0), 1);
    drain();
    rx();
    check("r1_rx", 32'(p0), 32'(NIL));
    cr_msms = 1'b1;
    head(10'h1A0, 1'b0);
    check("rs_start", 32'(p0), 32'(RS | KC));
    head(10'h1A0, 1'b1);
    check("rs_addr", 32'(p0), 32'(TS));
    head(10'h255, 1'b1);
    check("rs_stop", 32'(p0), 32'(MC | TC));
    drain();
    cr_msms = 1'b0;

    // 4: zero count, both modes
    head(10'h1A1, 1'b0);
    head(10'h1A1, 1'b1);
    head(10'h200, 1'b1);
    check("z0_err", 32'(p0), 32'(ER | AB));
    check("z1_load", 32'(p1), 32'(NIL));
    check("z1_rem", 32'(rem1), 0);
    check("z1_busy", 32'(busy1), 1);
    drain();
    check("z0_idle", 32'(busy0), 0);
    for (int i = 1; i <= 256; i++) begin
      rx();
      if (i == 255) begin
        check("z1_rx255", 32'(p1), 32'(KS));
      end else if (i == 256) begin
        check("z1_rx256", 32'(p1), 32'(MC));
      end else begin
        check("z1_rx", 32'(p1), 32'(NIL));
      end
      if (i == 1) check("z1_rem255", 32'(rem1), 255);
    end
    check("z1_idle", 32'(busy1), 0);

    // 5: arb_lost and cr_en drop in READ
    head(10'h1A1, 1'b0);
    head(10'h1A1, 1'b1);
    head(10'h205, 1'b1);
    drain();
    rx();
    check("al_rem", 32'(rem0), 4);
    arb_lost = 1'b1;
    rxw      = 1'b1;
    step();
    check("al_abort", 32'(p0), 32'(AB));
    check("al_busy", 32'(busy0), 0);
    check("al_rem0", 32'(rem0), 0);
    head(10'h1A1, 1'b0);
    head(10'h1A1, 1'b1);
    head(10'h205, 1'b1);
    drain();
    cr_en = 1'b0;
    rxw   = 1'b1;
    step();
    check("en_abort", 32'(p0), 32'(AB));
    check("en_busy", 32'(busy0), 0);
    step();
    check("en_quiet", 32'(p0), 32'(NIL));
    cr_en = 1'b1;

    // 6: reset mid-write, then start on push to empty FIFO
    head(10'h1A0, 1'b0);
    head(10'h1A0, 1'b1);
    head(10'h033, 1'b1);
    check("mr_busy", 32'(busy0), 1);
    rstn = 1'b0;
    head(10'h244, 1'b1);
    check("mr_pulse", 32'(p0), 32'(NIL));
    check("mr_idle", 32'(busy0), 0);
    rstn = 1'b1;
    drain();
    check("mr_quiet", 32'(p0), 32'(NIL));
    wr  = 1'b1;
    din = 10'h1A0;
    step();
    check("push_start", 32'(p0), 32'(MS | KC));
    check("push_busy", 32'(busy0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
